// File: rtl/ldmac_pkg.sv
// Shared LDMAC definitions: schedule FSM states, key/word widths and the
// per-word permutation used by the key-update step.
package ldmac_pkg;

  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Low half rotates left by 4, high half rotates right by 2.
  function automatic logic [WORD_W-1:0] perm_word(input logic [WORD_W-1:0] x);
    return {x[17:16], x[31:18], x[11:0], x[15:12]};
  endfunction

endpackage

// File: rtl/key_sched_ctrl_if.sv
// Round-key valid/ready channel from the key sequencer to the round datapath.
interface key_sched_ctrl_if #(
  parameter int IDX_W = 5
);
  logic                        rk_valid;
  logic                        rk_ready;
  logic [ldmac_pkg::WORD_W-1:0] rk_out;
  logic [IDX_W-1:0]            rk_idx;

  modport master (output rk_valid, output rk_out, output rk_idx, input rk_ready);
  modport slave  (input rk_valid, input rk_out, input rk_idx, output rk_ready);
endinterface

// File: rtl/key_step.sv
// One key-update step: rotate the four words down and permute the old word 0
// into the top word position.
module key_step
  import ldmac_pkg::*;
(
  input  logic [KEY_W-1:0] i_st,
  output logic [KEY_W-1:0] o_st
);
  assign o_st = {perm_word(i_st[WORD_W-1:0]), i_st[KEY_W-1:WORD_W]};
endmodule

// File: rtl/key_sched_ctrl.sv
// Round-key sequencer: holds the master key, steps the working key once per
// accepted round key, and supports reload and rewind from the stored key.
module key_sched_ctrl
  import ldmac_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  input  logic             rewind,
  output logic             done,
  key_sched_ctrl_if.master rk
);
  state_t           r_state;
  state_t           w_state_next;
  logic [KEY_W-1:0] r_mkey;
  logic [KEY_W-1:0] r_st;
  logic [KEY_W-1:0] w_st_step;
  logic [IDX_W-1:0] r_ctr;
  logic             r_have_key;
  logic             w_rewind;
  logic             w_hs;
  logic             w_last;

  key_step u_step (
    .i_st (r_st),
    .o_st (w_st_step)
  );

  // Rewind is meaningless without a stored key and loses to a fresh load.
  assign w_rewind = rewind & ~key_load & r_have_key;
  assign w_hs     = (r_state == ST_RUN) & rk.rk_ready;
  assign w_last   = (r_ctr == IDX_W'(ROUNDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (key_load || w_rewind) begin
      w_state_next = ST_RUN;
    end else if (w_hs && w_last) begin
      w_state_next = ST_DONE;
    end
  end

  // A handshake coinciding with load/rewind is dropped: the restart wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mkey     <= '0;
      r_st       <= '0;
      r_ctr      <= '0;
      r_have_key <= 1'b0;
    end else if (key_load) begin
      r_mkey     <= key_in;
      r_st       <= key_in;
      r_ctr      <= '0;
      r_have_key <= 1'b1;
    end else if (w_rewind) begin
      r_st  <= r_mkey;
      r_ctr <= '0;
    end else if (w_hs) begin
      r_st <= w_st_step;
      if (!w_last) begin
        r_ctr <= r_ctr + IDX_W'(1);
      end
    end
  end

  assign rk.rk_valid = (r_state == ST_RUN);
  assign rk.rk_out   = r_st[WORD_W-1:0];
  assign rk.rk_idx   = r_ctr;
  assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl: load, stalled schedules, rewind replay,
// load/rewind priority, mid-schedule reload and asynchronous reset.
module tb_key_sched_ctrl;
  import ldmac_pkg::*;

  localparam int ROUNDS = 32;
  localparam int IDX_W  = $clog2(ROUNDS);

  localparam logic [127:0] K1 = 128'h0000_0003_0000_0002_0000_0001_0001_000F;
  localparam logic [127:0] K2 = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
  localparam logic [127:0] K3 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic [127:0] key_in   = '0;
  logic         key_load = 1'b0;
  logic         rewind   = 1'b0;
  logic         done;

  int checks = 0;
  int errors = 0;

  key_sched_ctrl_if #(.IDX_W(IDX_W)) rk ();

  key_sched_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_load (key_load),
    .rewind   (rewind),
    .done     (done),
    .rk       (rk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] ref_step(input logic [127:0] s);
    logic [31:0] w0;
    logic [31:0] p;
    w0       = s[31:0];
    p[3:0]   = w0[15:12];
    p[15:4]  = w0[11:0];
    p[29:16] = w0[31:18];
    p[31:30] = w0[17:16];
    return {p, s[127:32]};
  endfunction

  // Consume a full schedule starting from key word 0, with optional random stalls.
  task automatic run_schedule(input string tag, input logic [127:0] key, input bit stall);
    logic [127:0] m_st;
    int           n;
    int           cyc;
    m_st = key;
    n    = 0;
    cyc  = 0;
    while (n < ROUNDS && cyc < 1000) begin
      chk({tag, "_valid"}, rk.rk_valid, 1'b1);
      chk({tag, "_out"}, rk.rk_out, m_st[31:0]);
      chk({tag, "_idx"}, rk.rk_idx, n);
      chk({tag, "_done_low"}, done, 1'b0);
      rk.rk_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rk.rk_ready) begin
        m_st = ref_step(m_st);
        n++;
      end
      tick();
      cyc++;
    end
    rk.rk_ready = 1'b0;
    chk({tag, "_hs_count"}, n, ROUNDS);
    chk({tag, "_end_done"}, done, 1'b1);
    chk({tag, "_end_valid"}, rk.rk_valid, 1'b0);
    chk({tag, "_end_st"}, dut.r_st, m_st);
    tick();
    chk({tag, "_hold_done"}, done, 1'b1);
  endtask

  initial begin
    rk.rk_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Idle after reset.
    repeat (5) tick();
    chk("rst_valid", rk.rk_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", rk.rk_out, 32'h0);
    chk("rst_idx", rk.rk_idx, 0);

    // Rewind without a stored key is ignored.
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    tick();
    chk("nokey_rewind_valid", rk.rk_valid, 1'b0);
    chk("nokey_rewind_done", done, 1'b0);

    // Load K1 and take two keys back to back.
    key_in      = K1;
    key_load    = 1'b1;
    rk.rk_ready = 1'b1;
    tick();
    key_load = 1'b0;
    chk("load_valid", rk.rk_valid, 1'b1);
    chk("load_out0", rk.rk_out, 32'h0001_000F);
    chk("load_idx0", rk.rk_idx, 0);
    tick();
    chk("step1_out", rk.rk_out, 32'h0000_0001);
    chk("step1_idx", rk.rk_idx, 1);
    chk("step1_st", dut.r_st, 128'h4000_00F0_0000_0003_0000_0002_0000_0001);
    rk.rk_ready = 1'b0;

    // Restart and run a stalled full schedule.
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    run_schedule("sched", K1, 1'b1);

    // Rewind from DONE replays the same sequence.
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    run_schedule("replay", K1, 1'b1);

    // Load and rewind together: the new key wins.
    key_in   = K2;
    key_load = 1'b1;
    rewind   = 1'b1;
    tick();
    key_load = 1'b0;
    rewind   = 1'b0;
    chk("prio_out", rk.rk_out, K2[31:0]);
    chk("prio_idx", rk.rk_idx, 0);
    chk("prio_valid", rk.rk_valid, 1'b1);

    // Advance to idx 10, then reload with a handshake in the same cycle.
    rk.rk_ready = 1'b1;
    repeat (10) tick();
    chk("mid_idx10", rk.rk_idx, 10);
    key_in   = K3;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("reload_idx", rk.rk_idx, 0);
    chk("reload_out", rk.rk_out, K3[31:0]);
    chk("reload_valid", rk.rk_valid, 1'b1);

    // Reset asserted at idx 5 clears outputs without waiting for a clock edge.
    repeat (5) tick();
    chk("pre_rst_idx5", rk.rk_idx, 5);
    rk.rk_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rk.rk_valid, 1'b0);
    chk("async_rst_out", rk.rk_out, 32'h0);
    chk("async_rst_idx", rk.rk_idx, 0);
    chk("async_rst_done", done, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Stored key was lost, so rewind stays ignored.
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    tick();
    chk("post_rst_rewind_valid", rk.rk_valid, 1'b0);
    chk("post_rst_rewind_out", rk.rk_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Round-key sequencer for the LDMAC core. It latches a 128-bit master key and applies the one-step key-update permutation once per accepted round key. Round keys go to the round datapath over a valid/ready handshake, each tagged with its round index. A rewind input restarts the schedule from the stored master key without reloading it.

## Interface
- ROUNDS, 32, number of round keys per schedule (>= 2)
- IDX_W, $clog2(ROUNDS), width of round index

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_in  in  128  master key; sampled when key_load=1
- key_load  in  1  load master key and start a new schedule (single-cycle strobe)
- rewind  in  1  restart the schedule from the stored master key
- rk_valid  out  1  round key available
- rk_ready  in  1  consumer accepts round key
- rk_out  out  32  current round key = state word 0 (bits 31:0)
- rk_idx  out  IDX_W  round index of rk_out
- done  out  1  high while all ROUNDS keys have been consumed

## Operation
- Registers:
  - mkey (128): master copy.
  - st (128): working key.
  - ctr (IDX_W): round counter.
  - have_key (1): a master key has been loaded.
  - FSM: IDLE, RUN, DONE.
- Step function, with st = {w3,w2,w1,w0}: next = {P(w0), w3, w2, w1}.
- P(x), low half: P[15:0] = x[15:0] rotated left by 4, i.e. P[3:0]=x[15:12] and P[15:4]=x[11:0].
- P(x), high half: P[31:16] = x[31:16] rotated right by 2, i.e. P[29:16]=x[31:18] and P[31:30]=x[17:16].
- IDLE: rk_valid=0, done=0.
- Any state, key_load=1: mkey<=key_in, st<=key_in, ctr<=0, have_key<=1, go to RUN.
- Any state, rewind=1 with key_load=0 and have_key=1: st<=mkey, ctr<=0, go to RUN. rewind with have_key=0 is ignored.
- RUN: rk_valid=1, rk_out=st[31:0], rk_idx=ctr.
  - Handshake (rk_valid & rk_ready): st<=step(st).
  - If ctr==ROUNDS-1, go to DONE; otherwise ctr<=ctr+1.
- DONE: rk_valid=0, done=1. st holds the post-final-step value. Only key_load or rewind leaves DONE.
- Priority: key_load > rewind > handshake.
  - A handshake in the same cycle as key_load or rewind counts as accepted by the consumer, but it does not advance the schedule; the reload wins.
- rk_valid never drops in RUN without a handshake or a load/rewind. rk_out and rk_idx are stable while rk_valid=1 and rk_ready=0.

## Timing
- Reset (async assert, sync deassert expected upstream): FSM=IDLE; mkey, st, ctr, have_key = 0; rk_valid=0, rk_out=0, rk_idx=0, done=0.
- Reset asserted mid-schedule aborts immediately. The stored key is lost, so rewind after reset is ignored until the next key_load.
- key_load or rewind at edge N: rk_valid=1 from cycle N+1, with rk_out=key word 0 and rk_idx=0.
- One step per handshake edge. With rk_ready held high, ROUNDS consecutive cycles of rk_valid, then done=1 on the following cycle.
- rk_out, rk_idx, rk_valid and done are all direct register or FSM-decode outputs. There is no combinational path from rk_ready to any output.
- Round counter never wraps. The RUN→DONE transition replaces the increment at ROUNDS-1.

## Structure
- Shared package (ldmac_pkg):
  - FSM state enum (IDLE/RUN/DONE).
  - KEY_W=128, WORD_W=32.
  - Function perm_word implementing P.
- One combinational sub-module, key_step: 128-bit in, 128-bit out, implementing the step function. The FSM, counters and registers live in key_sched_ctrl.

## Test plan
- Reset, then idle for 5 cycles → rk_valid=0, done=0, rk_out=0. Pulse rewind → no change (have_key=0).
- Load key_in=0000_0003_0000_0002_0000_0001_0001_000F with rk_ready=1 → cycle+1: rk_out=0001_000F, idx 0. Next: rk_out=0000_0001, idx 1. Internal st after step 1 = 4000_00F0_0000_0003_0000_0002_0000_0001.
- Drive rk_ready with a random stall pattern for a full schedule (ROUNDS=32) → exactly 32 handshakes with idx 0..31, outputs stable during stalls, then done=1 and rk_valid=0. Compare against a step-function reference model.
- After DONE, pulse rewind → identical 32-key sequence replayed starting at idx 0. Then key_load and rewind in the same cycle with a new key → new key wins.
- Mid-schedule (idx 10), assert key_load with a handshake in the same cycle → next cycle idx 0, rk_out = new key word 0. Assert rst_n low at idx 5 → all outputs 0 in the same cycle (asynchronous).
